// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: key sync/edge detect, 1 s divider, two-digit BCD count, lap latch.
// Optional key debounce filter enabled by defining STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl #(
    parameter int unsigned DIV       = 50000000,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       RS,
    input  logic       KEY_START_N,
    input  logic       KEY_LAP_N,
    input  logic       KEY_CLR_N,
    output logic [3:0] dv,
    output logic [3:0] ch,
    output logic [1:0] state,
    output logic       tick,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam int unsigned DW = (DIV > 2) ? $clog2(DIV) : 1;

    state_t      st, st_nxt;
    logic [2:0]  keys_n, sync1, sync2, lvl, prev, press;
    logic        press_start, press_lap, press_clr;
    logic [DW-1:0] div_cnt;
    logic [3:0]  units, tens, lap_u, lap_t;
    logic [3:0]  u_nxt, t_nxt, disp_u, disp_t;
    logic        counting, tick_now, wrap_now, clr_go;

    // Bit order: 0 start, 1 lap, 2 clear
    assign keys_n = {KEY_CLR_N, KEY_LAP_N, KEY_START_N};

    always_ff @(posedge CLOCK_50 or posedge RS) begin
        if (RS) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= keys_n;
            sync2 <= sync1;
            prev  <= lvl;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [2:0]    filt;
    logic [CW-1:0] db_cnt [3];

    // Filtered level flips only after DB_CYCLES consecutive cycles of disagreement
    always_ff @(posedge CLOCK_50 or posedge RS) begin
        if (RS) begin
            filt <= '1;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = filt;
`else
    assign lvl = sync2;
`endif

    assign press       = prev & ~lvl;
    assign press_start = press[0];
    assign press_lap   = press[1];
    assign press_clr   = press[2];

    always_ff @(posedge CLOCK_50 or posedge RS) begin
        if (RS) st <= IDLE;
        else    st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        unique case (st)
            IDLE:  if (press_start) st_nxt = RUN;
            RUN:   if (press_start) st_nxt = PAUSE;
                   else if (press_lap) st_nxt = LAP;
            LAP:   if (press_start) st_nxt = PAUSE;
                   else if (press_lap) st_nxt = RUN;
            PAUSE: if (press_clr) st_nxt = IDLE;
                   else if (press_start) st_nxt = RUN;
            default: st_nxt = IDLE;
        endcase
    end

    assign counting = (st == RUN) || (st == LAP);
    assign tick_now = counting && (div_cnt == DW'(DIV - 1));
    assign clr_go   = (st == PAUSE) && (st_nxt == IDLE);

    // Next internal count: BCD increment on tick, zero on clear
    always_comb begin
        u_nxt    = units;
        t_nxt    = tens;
        wrap_now = 1'b0;
        if (clr_go) begin
            u_nxt = '0;
            t_nxt = '0;
        end else if (tick_now) begin
            if (units == 4'd9) begin
                u_nxt = '0;
                if (tens == 4'd9) begin
                    t_nxt    = '0;
                    wrap_now = 1'b1;
                end else begin
                    t_nxt = tens + 4'd1;
                end
            end else begin
                u_nxt = units + 4'd1;
            end
        end
    end

    // Outputs: encoded state and next displayed digits (lap value frozen while in LAP)
    always_comb begin
        state  = st;
        disp_u = u_nxt;
        disp_t = t_nxt;
        if (st_nxt == LAP && st == LAP) begin
            disp_u = lap_u;
            disp_t = lap_t;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RS) begin
        if (RS) begin
            div_cnt <= '0;
            units   <= '0;
            tens    <= '0;
            lap_u   <= '0;
            lap_t   <= '0;
            dv      <= '0;
            ch      <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            if (counting)
                div_cnt <= tick_now ? '0 : div_cnt + 1'b1;
            else if (st == IDLE || clr_go)
                div_cnt <= '0;
            units <= u_nxt;
            tens  <= t_nxt;
            if (st == RUN && st_nxt == LAP) begin
                lap_u <= u_nxt;
                lap_t <= t_nxt;
            end
            dv   <= disp_u;
            ch   <= disp_t;
            tick <= tick_now;
            wrap <= wrap_now;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (DIV=4, DB_CYCLES=8); table-driven FSM vectors,
// scoreboard queue, and hand sequences for counting, pause/resume, lap, clear and reset.
module tb_stopwatch_ctrl;

    localparam int DIVP = 4;
    localparam int DBP  = 8;
`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int LAT_ADD = DBP;
`else
    localparam int LAT_ADD = 0;
`endif
    localparam int SKIP = LAT_ADD / DIVP;
    localparam int HOLD = 3 + LAT_ADD + 1;
    localparam int GAP  = 4 + 2 * LAT_ADD;

    logic       clk = 1'b0;
    logic       rs  = 1'b1;
    logic       k_start = 1'b1, k_lap = 1'b1, k_clr = 1'b1;
    logic [3:0] dv, ch;
    logic [1:0] state;
    logic       tick, wrap;

    stopwatch_ctrl #(.DIV(DIVP), .DB_CYCLES(DBP)) dut (
        .CLOCK_50(clk), .RS(rs),
        .KEY_START_N(k_start), .KEY_LAP_N(k_lap), .KEY_CLR_N(k_clr),
        .dv(dv), .ch(ch), .state(state), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [3:0] d;
        logic [3:0] c;
        bit         digits;
    } exp_t;

    typedef struct {
        string      name;
        logic [2:0] keys;   // bit0 start, bit1 lap, bit2 clear
        logic [1:0] st;
        bit         digits;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[13];
    int   tests = 0;
    int   fails = 0;
    int   stray_wrap = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT, expected event", name);
    endtask

    task automatic push_exp(input string name, input logic [1:0] st,
                            input logic [3:0] d, input logic [3:0] c, input bit digits);
        exp_t e;
        e.name = name; e.st = st; e.d = d; e.c = c; e.digits = digits;
        exp_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            timeout("scoreboard_empty");
            return;
        end
        e = exp_q.pop_front();
        check({e.name, "_state"}, int'(state), int'(e.st));
        if (e.digits) begin
            check({e.name, "_dv"}, int'(dv), int'(e.d));
            check({e.name, "_ch"}, int'(ch), int'(e.c));
        end
    endtask

    task automatic set_keys(input logic [2:0] m);
        k_start = ~m[0];
        k_lap   = ~m[1];
        k_clr   = ~m[2];
    endtask

    task automatic press(input logic [2:0] m);
        @(negedge clk);
        set_keys(m);
        repeat (HOLD) @(negedge clk);
        set_keys(3'b000);
        repeat (GAP) @(negedge clk);
    endtask

    task automatic wait_state(input string name, input logic [1:0] st, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (state == st) return;
        end
        timeout(name);
    endtask

    task automatic wait_tick_at(input string name, input int c, input int d, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (tick && int'(dv) == d && int'(ch) == c) return;
        end
        timeout(name);
    endtask

    task automatic wait_tick(input string name, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 4 * DIVP; i++) begin
            @(negedge clk);
            if (wrap && !tick) stray_wrap++;
            if (tick) begin
                cyc = i;
                return;
            end
        end
        timeout(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_keys(3'b000);
        rs = 1'b1;
        repeat (2) @(negedge clk);
        rs = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clk);
        k_start = 1'b0;
        wait_state("start_run", 2'b01, HOLD + 4);
        k_start = 1'b1;
    endtask

    initial begin
        int n, cyc;

        vecs[0]  = '{"idle_lap",    3'b010, 2'b00, 1'b1};
        vecs[1]  = '{"idle_clr",    3'b100, 2'b00, 1'b1};
        vecs[2]  = '{"idle_start",  3'b001, 2'b01, 1'b0};
        vecs[3]  = '{"run_clr",     3'b100, 2'b01, 1'b0};
        vecs[4]  = '{"run_lap",     3'b010, 2'b11, 1'b0};
        vecs[5]  = '{"lap_clr",     3'b100, 2'b11, 1'b0};
        vecs[6]  = '{"lap_start",   3'b001, 2'b10, 1'b0};
        vecs[7]  = '{"pause_lap",   3'b010, 2'b10, 1'b0};
        vecs[8]  = '{"pause_start", 3'b001, 2'b01, 1'b0};
        vecs[9]  = '{"run_lap2",    3'b010, 2'b11, 1'b0};
        vecs[10] = '{"lap_lap",     3'b010, 2'b01, 1'b0};
        vecs[11] = '{"run_start",   3'b001, 2'b10, 1'b0};
        vecs[12] = '{"pause_clr",   3'b100, 2'b00, 1'b1};

        // Reset state while RS is held
        repeat (3) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_dv", int'(dv), 0);
        check("rst_ch", int'(ch), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_wrap", int'(wrap), 0);
        rs = 1'b0;
        repeat (2) @(negedge clk);

        // FSM transition table
        for (int i = 0; i < 13; i++) begin
            push_exp(vecs[i].name, vecs[i].st, 4'd0, 4'd0, vecs[i].digits);
            press(vecs[i].keys);
            check_pop();
        end

        // Counting: tick spacing, BCD stepping, 99 -> 00 wrap
        do_reset();
        start_run();
        n = 0;
        for (int k = 1; k <= 101; k++) begin
            wait_tick($sformatf("tick_%0d", k), cyc);
            n = (n + 1) % 100;
            check($sformatf("tick_spacing_%0d", k), cyc, DIVP);
            check($sformatf("count_%0d", k), int'(ch) * 10 + int'(dv), n);
            check($sformatf("wrap_%0d", k), int'(wrap), (n == 0) ? 1 : 0);
        end
        check("stray_wrap", stray_wrap, 0);

        // Pause at divider phase 2 with count 03, resume from held divider, clear
        do_reset();
        start_run();
        press(3'b100);
        check("run_clr_ignored", int'(state), 1);
        wait_tick_at("wait_03", 0, 3 - SKIP, 500);
        k_start = 1'b0;
        push_exp("pause_at_03", 2'b10, 4'd3, 4'd0, 1'b1);
        wait_state("enter_pause", 2'b10, HOLD + 4);
        k_start = 1'b1;
        repeat (20) @(negedge clk);
        check_pop();
        @(negedge clk);
        k_start = 1'b0;
        wait_state("resume", 2'b01, HOLD + 4);
        k_start = 1'b1;
        cyc = 99;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (tick) begin
                cyc = i;
                break;
            end
        end
        check("resume_tick_within_2", (cyc <= 2) ? 1 : 0, 1);
        check("resume_dv", int'(dv), 4);
        push_exp("pause_again", 2'b10, 4'd0, 4'd0, 1'b0);
        press(3'b001);
        check_pop();
        push_exp("pause_clear", 2'b00, 4'd0, 4'd0, 1'b1);
        press(3'b100);
        check_pop();

        // START press coinciding with a tick: increment lands, then PAUSE
        start_run();
        wait_tick_at("wait_05", 0, 5 - SKIP, 200);
        @(negedge clk);
        k_start = 1'b0;
        push_exp("pause_on_tick", 2'b10, 4'd6, 4'd0, 1'b1);
        wait_state("enter_pause_tick", 2'b10, HOLD + 4);
        k_start = 1'b1;
        repeat (12) @(negedge clk);
        check_pop();

        // START and CLR together in PAUSE: clear wins
        push_exp("pause_start_clr", 2'b00, 4'd0, 4'd0, 1'b1);
        press(3'b101);
        check_pop();

        // LAP freezes the display at 05 while counting continues
        do_reset();
        start_run();
        wait_tick_at("wait_lap05", 0, 5 - SKIP, 200);
        k_lap = 1'b0;
        push_exp("lap_entry", 2'b11, 4'd5, 4'd0, 1'b1);
        wait_state("enter_lap", 2'b11, HOLD + 4);
        k_lap = 1'b1;
        check_pop();
        for (int k = 1; k <= 3; k++) begin
            wait_tick($sformatf("lap_tick_%0d", k), cyc);
            check($sformatf("lap_hold_dv_%0d", k), int'(dv), 5);
            check($sformatf("lap_hold_ch_%0d", k), int'(ch), 0);
            check($sformatf("lap_hold_state_%0d", k), int'(state), 3);
            if (k == 3 - SKIP) k_lap = 1'b0;
        end
        push_exp("lap_exit", 2'b01, 4'd8, 4'd0, 1'b1);
        wait_state("exit_lap", 2'b01, HOLD + 4);
        k_lap = 1'b1;
        check_pop();

        // Asynchronous reset mid-RUN at count 47
        do_reset();
        start_run();
        wait_tick_at("wait_47", 4, 7, 300);
        @(posedge clk);
        #2 rs = 1'b1;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_dv", int'(dv), 0);
        check("async_rst_ch", int'(ch), 0);
        repeat (2) @(negedge clk);
        rs = 1'b0;
        repeat (2) @(negedge clk);

`ifdef STOPWATCH_DEBOUNCE_EN
        // Short glitch is filtered; a long press gives exactly one transition
        k_start = 1'b0;
        repeat (5) @(negedge clk);
        k_start = 1'b1;
        repeat (20) @(negedge clk);
        check("db_glitch", int'(state), 0);
        k_start = 1'b0;
        repeat (12) @(negedge clk);
        k_start = 1'b1;
        repeat (30) @(negedge clk);
        check("db_long_press", int'(state), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
